// File: rtl/alu_operand_sequencer_if.sv
// Bus between the operand sequencer and its surroundings: board inputs, ALU
// operand/result lines and the display/status outputs.
interface alu_operand_sequencer_if #(
   parameter int N = 16
);
   logic [N-1:0] data_in;
   logic         enter;
   logic         clear;
   logic [N-1:0] OP1;
   logic [N-1:0] OP2;
   logic [1:0]   OpCode;
   logic [N-1:0] alu_result;
   logic         alu_status;
   logic [N-1:0] display_value;
   logic [2:0]   stage;
   logic         result_valid;
   logic         overflow;

   modport master (
      input  data_in, enter, clear, alu_result, alu_status,
      output OP1, OP2, OpCode, display_value, stage, result_valid, overflow
   );

   modport slave (
      output data_in, enter, clear, alu_result, alu_status,
      input  OP1, OP2, OpCode, display_value, stage, result_valid, overflow
   );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Collects OP1, OP2 and opcode from one shared switch bus on enter edges,
// holds them on the ALU, captures the result one cycle later and supports chaining.
module alu_operand_sequencer #(
   parameter int N = 16
) (
   input  logic                     clk,
   input  logic                     resetN,
   alu_operand_sequencer_if.master  bus
);

   typedef enum logic [2:0] {
      WAIT_OP1,
      WAIT_OP2,
      WAIT_OPCODE,
      EXEC,
      SHOW_RESULT
   } state_t;

   state_t       state;
   logic         enter_prev;
   logic         enter_edge;
   logic [N-1:0] result_reg;

   // A held button is one event: only the rising edge advances the sequence.
   assign enter_edge = bus.enter & ~enter_prev;

   // NOTE: reset is synchronous (sampled on the clock edge) and all state uses
   // non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         state        <= WAIT_OP1;
         enter_prev   <= 1'b0;
         bus.OP1      <= '0;
         bus.OP2      <= '0;
         bus.OpCode   <= 2'b00;
         result_reg   <= '0;
         bus.overflow <= 1'b0;
      end else begin
         enter_prev <= bus.enter;
         if (bus.clear) begin
            state        <= WAIT_OP1;
            bus.OP1      <= '0;
            bus.OP2      <= '0;
            bus.OpCode   <= 2'b00;
            result_reg   <= '0;
            bus.overflow <= 1'b0;
         end else begin
            unique case (state)
               WAIT_OP1: if (enter_edge) begin
                  bus.OP1 <= bus.data_in;
                  state   <= WAIT_OP2;
               end
               WAIT_OP2: if (enter_edge) begin
                  bus.OP2 <= bus.data_in;
                  state   <= WAIT_OPCODE;
               end
               WAIT_OPCODE: if (enter_edge) begin
                  bus.OpCode <= bus.data_in[1:0];
                  state      <= EXEC;
               end
               EXEC: begin
                  // Operands have been stable for a full cycle; ALU has settled.
                  result_reg   <= bus.alu_result;
                  bus.overflow <= bus.alu_status;
                  state        <= SHOW_RESULT;
               end
               SHOW_RESULT: if (enter_edge) begin
                  bus.OP1      <= result_reg;
                  bus.overflow <= 1'b0;
                  state        <= WAIT_OP2;
               end
               default: state <= WAIT_OP1;
            endcase
         end
      end
   end

   // NOTE: every output gets a default first so no latch is inferred.
   always_comb begin
      bus.stage         = 3'b000;
      bus.result_valid  = 1'b0;
      bus.display_value = '0;
      unique case (state)
         WAIT_OP1: begin
            bus.stage         = 3'b001;
            bus.display_value = bus.data_in;
         end
         WAIT_OP2: begin
            bus.stage         = 3'b010;
            bus.display_value = bus.data_in;
         end
         WAIT_OPCODE: begin
            bus.stage         = 3'b100;
            bus.display_value = {{(N-2){1'b0}}, bus.data_in[1:0]};
         end
         EXEC:        bus.display_value = bus.OP2;
         SHOW_RESULT: begin
            bus.result_valid  = 1'b1;
            bus.display_value = result_reg;
         end
         default: ;
      endcase
   end

endmodule
